// File: rtl/call_stack_pkg.sv
// call_stack_pkg: shared op encoding, default sizes and push/pop decode for the return-address stack
package call_stack_pkg;

    localparam int CS_DATA_W = 32;
    localparam int CS_DEPTH  = 16;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_PUSH,
        OP_POP,
        OP_REPL
    } stack_op_t;

    // push+pop on an empty stack degrades to a plain push, so it never raises underflow
    function automatic stack_op_t decode_op(input logic push, input logic pop, input logic empty);
        return (push && pop && !empty) ? OP_REPL : push ? OP_PUSH : pop ? OP_POP : OP_NOP;
    endfunction

endpackage

// File: rtl/call_stack_lifo_ram.sv
// lifo_ram: DEPTH x DATA_W storage with one synchronous write port and one asynchronous read port
module lifo_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // entries are never reset; only live slots below the write pointer are ever observed
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/call_stack.sv
// call_stack: circular LIFO of return PCs with push/pop/replace/flush and sticky over/underflow
// Build option: define CALL_STACK_OVF_WRAP_EN to let a push on a full stack overwrite the oldest entry
module call_stack
    import call_stack_pkg::*;
#(
    parameter  int DATA_W = CS_DATA_W,
    parameter  int DEPTH  = CS_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic              clr_err,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] top,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]  wp_q, wp_d, top_ptr, waddr;
    logic [PTR_W:0]    count_q, count_d;
    logic              ovf_q, ovf_d, unf_q, unf_d, we;
    logic [DATA_W-1:0] rdata;
    stack_op_t         op;

    assign top_ptr   = wp_q - PTR_W'(1);
    assign empty     = count_q == '0;
    assign full      = count_q == FULL_CNT;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign top       = empty ? '0 : rdata;
    assign op        = decode_op(push, pop, empty);

    // next-state: flush beats push/pop; a fresh error overrides clr_err in the same cycle
    always_comb begin
        wp_d    = wp_q;
        count_d = count_q;
        ovf_d   = ovf_q & ~clr_err;
        unf_d   = unf_q & ~clr_err;
        we      = 1'b0;
        waddr   = wp_q;
        if (flush) begin
            wp_d    = '0;
            count_d = '0;
        end else begin
            case (op)
                OP_PUSH: begin
                    if (!full) begin
                        we      = 1'b1;
                        wp_d    = wp_q + PTR_W'(1);
                        count_d = count_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
`ifdef CALL_STACK_OVF_WRAP_EN
                        we    = 1'b1;
                        wp_d  = wp_q + PTR_W'(1);
`endif
                    end
                end
                OP_POP: begin
                    if (!empty) begin
                        wp_d    = top_ptr;
                        count_d = count_q - 1'b1;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
                OP_REPL: begin
                    we    = 1'b1;
                    waddr = top_ptr;
                end
                default: ;
            endcase
        end
    end

    // pointer, occupancy and sticky flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    lifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PTR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we & ~rst),
        .waddr_i (waddr),
        .wdata_i (data_in),
        .raddr_i (top_ptr),
        .rdata_o (rdata)
    );

endmodule
